// File: rtl/alu_pipe.sv
// Pipelined execute-stage ALU with valid/ready handshakes, flush, and STAGES register stages.
// Optional stat_ops/stat_stalls counters are enabled by defining ALU_PIPE_STATS_EN.
package mips_core_pkg;
    typedef logic [4:0] alu_ctl_t;

    localparam alu_ctl_t ALUCTL_ADD       = 5'd0;
    localparam alu_ctl_t ALUCTL_ADDU      = 5'd1;
    localparam alu_ctl_t ALUCTL_SUB       = 5'd2;
    localparam alu_ctl_t ALUCTL_SUBU      = 5'd3;
    localparam alu_ctl_t ALUCTL_AND       = 5'd4;
    localparam alu_ctl_t ALUCTL_OR        = 5'd5;
    localparam alu_ctl_t ALUCTL_XOR       = 5'd6;
    localparam alu_ctl_t ALUCTL_NOR       = 5'd7;
    localparam alu_ctl_t ALUCTL_SLT       = 5'd8;
    localparam alu_ctl_t ALUCTL_SLTU      = 5'd9;
    localparam alu_ctl_t ALUCTL_SLL       = 5'd10;
    localparam alu_ctl_t ALUCTL_SRL       = 5'd11;
    localparam alu_ctl_t ALUCTL_SRA       = 5'd12;
    localparam alu_ctl_t ALUCTL_SLLV      = 5'd13;
    localparam alu_ctl_t ALUCTL_SRLV      = 5'd14;
    localparam alu_ctl_t ALUCTL_SRAV      = 5'd15;
    localparam alu_ctl_t ALUCTL_BA        = 5'd16;
    localparam alu_ctl_t ALUCTL_BEQ       = 5'd17;
    localparam alu_ctl_t ALUCTL_BNE       = 5'd18;
    localparam alu_ctl_t ALUCTL_BLEZ      = 5'd19;
    localparam alu_ctl_t ALUCTL_BGTZ      = 5'd20;
    localparam alu_ctl_t ALUCTL_BGEZ      = 5'd21;
    localparam alu_ctl_t ALUCTL_BLTZ      = 5'd22;
    localparam alu_ctl_t ALUCTL_NOP       = 5'd23;
    localparam alu_ctl_t ALUCTL_MTC0_PASS = 5'd24;
    localparam alu_ctl_t ALUCTL_MTC0_FAIL = 5'd25;
    localparam alu_ctl_t ALUCTL_MTC0_DONE = 5'd26;

    localparam logic BR_TAKEN     = 1'b1;
    localparam logic BR_NOT_TAKEN = 1'b0;
endpackage

module alu_pipe
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_ctl_t              in_alu_ctl,
    input  logic [DATA_WIDTH-1:0] in_op1,
    input  logic [DATA_WIDTH-1:0] in_op2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_pass,
    output logic                  out_fail,
    output logic                  out_done,
    output logic [DATA_WIDTH-1:0] out_mtc0_op,
    output logic                  out_illegal
`ifdef ALU_PIPE_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_stalls
`endif
);

    localparam int unsigned SHW  = $clog2(DATA_WIDTH);
    localparam int unsigned LAST = STAGES - 1;

    logic [DATA_WIDTH-1:0] calc_result, calc_mtc0;
    logic                  calc_pass, calc_fail, calc_done, calc_illegal;
    logic                  bit_res, use_bit;
    logic [SHW-1:0]        sh_op1, sh_op2;

    assign sh_op1 = in_op1[SHW-1:0];
    assign sh_op2 = in_op2[SHW-1:0];

    always_comb begin
        calc_result  = '0;
        calc_mtc0    = '0;
        calc_pass    = 1'b0;
        calc_fail    = 1'b0;
        calc_done    = 1'b0;
        calc_illegal = 1'b0;
        bit_res      = 1'b0;
        use_bit      = 1'b0;
        case (in_alu_ctl)
            ALUCTL_ADD, ALUCTL_ADDU: calc_result = in_op1 + in_op2;
            ALUCTL_SUB, ALUCTL_SUBU: calc_result = in_op1 - in_op2;
            ALUCTL_AND:  calc_result = in_op1 & in_op2;
            ALUCTL_OR:   calc_result = in_op1 | in_op2;
            ALUCTL_XOR:  calc_result = in_op1 ^ in_op2;
            ALUCTL_NOR:  calc_result = ~(in_op1 | in_op2);
            ALUCTL_SLT:  begin use_bit = 1'b1; bit_res = $signed(in_op1) < $signed(in_op2); end
            ALUCTL_SLTU: begin use_bit = 1'b1; bit_res = in_op1 < in_op2; end
            ALUCTL_SLL:  calc_result = in_op1 << sh_op2;
            ALUCTL_SRL:  calc_result = in_op1 >> sh_op2;
            ALUCTL_SRA:  calc_result = $signed(in_op1) >>> sh_op2;
            ALUCTL_SLLV: calc_result = in_op2 << sh_op1;
            ALUCTL_SRLV: calc_result = in_op2 >> sh_op1;
            ALUCTL_SRAV: calc_result = $signed(in_op2) >>> sh_op1;
            ALUCTL_BA:   begin use_bit = 1'b1; bit_res = BR_TAKEN; end
            ALUCTL_BEQ:  begin use_bit = 1'b1; bit_res = (in_op1 == in_op2) ? BR_TAKEN : BR_NOT_TAKEN; end
            ALUCTL_BNE:  begin use_bit = 1'b1; bit_res = (in_op1 != in_op2) ? BR_TAKEN : BR_NOT_TAKEN; end
            ALUCTL_BLEZ: begin
                use_bit = 1'b1;
                bit_res = (in_op1[DATA_WIDTH-1] || in_op1 == '0) ? BR_TAKEN : BR_NOT_TAKEN;
            end
            ALUCTL_BGTZ: begin
                use_bit = 1'b1;
                bit_res = (!in_op1[DATA_WIDTH-1] && in_op1 != '0) ? BR_TAKEN : BR_NOT_TAKEN;
            end
            ALUCTL_BGEZ: begin use_bit = 1'b1; bit_res = !in_op1[DATA_WIDTH-1] ? BR_TAKEN : BR_NOT_TAKEN; end
            ALUCTL_BLTZ: begin use_bit = 1'b1; bit_res = in_op1[DATA_WIDTH-1] ? BR_TAKEN : BR_NOT_TAKEN; end
            ALUCTL_NOP:  calc_result = '0;
            ALUCTL_MTC0_PASS: begin calc_pass = 1'b1; calc_mtc0 = in_op2; end
            ALUCTL_MTC0_FAIL: begin calc_fail = 1'b1; calc_mtc0 = in_op2; end
            ALUCTL_MTC0_DONE: begin calc_done = 1'b1; calc_mtc0 = in_op2; end
            default:     calc_illegal = 1'b1;
        endcase
        if (use_bit) calc_result = {{(DATA_WIDTH-1){1'b0}}, bit_res};
    end

    logic [STAGES-1:0]     valid_q, valid_d, pass_q, pass_d, fail_q, fail_d;
    logic [STAGES-1:0]     done_q, done_d, illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] result_q [STAGES];
    logic [DATA_WIDTH-1:0] result_d [STAGES];
    logic [DATA_WIDTH-1:0] mtc0_q   [STAGES];
    logic [DATA_WIDTH-1:0] mtc0_d   [STAGES];
    logic [TAG_WIDTH-1:0]  tag_q    [STAGES];
    logic [TAG_WIDTH-1:0]  tag_d    [STAGES];
    logic [STAGES-1:0]     ld;
    logic                  accept, fire;

    // Stage k may load when empty or when it is itself moving on; walk from the output back.
    always_comb begin
        logic chain;
        ld    = '0;
        chain = !valid_q[LAST] || out_ready;
        ld[LAST] = chain;
        for (int unsigned i = 1; i < STAGES; i++) begin
            chain = !valid_q[LAST-i] || chain;
            ld[LAST-i] = chain;
        end
    end

    assign in_ready = !flush && ld[0];
    assign accept   = in_valid && in_ready;
    assign fire     = valid_q[LAST] && out_ready;

    always_comb begin
        valid_d   = valid_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        done_d    = done_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        mtc0_d    = mtc0_q;
        tag_d     = tag_q;
        if (ld[0]) valid_d[0] = accept;
        if (accept) begin
            result_d[0]  = calc_result;
            mtc0_d[0]    = calc_mtc0;
            tag_d[0]     = in_tag;
            pass_d[0]    = calc_pass;
            fail_d[0]    = calc_fail;
            done_d[0]    = calc_done;
            illegal_d[0] = calc_illegal;
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                valid_d[k]   = valid_q[k-1];
                result_d[k]  = result_q[k-1];
                mtc0_d[k]    = mtc0_q[k-1];
                tag_d[k]     = tag_q[k-1];
                pass_d[k]    = pass_q[k-1];
                fail_d[k]    = fail_q[k-1];
                done_d[k]    = done_q[k-1];
                illegal_d[k] = illegal_q[k-1];
            end
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            done_q    <= '0;
            illegal_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                result_q[k] <= '0;
                mtc0_q[k]   <= '0;
                tag_q[k]    <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            mtc0_q    <= mtc0_d;
            tag_q     <= tag_d;
        end
    end

    assign out_valid   = valid_q[LAST];
    assign out_result  = result_q[LAST];
    assign out_tag     = tag_q[LAST];
    assign out_mtc0_op = mtc0_q[LAST];
    assign out_pass    = valid_q[LAST] && pass_q[LAST];
    assign out_fail    = valid_q[LAST] && fail_q[LAST];
    assign out_done    = valid_q[LAST] && done_q[LAST];
    assign out_illegal = valid_q[LAST] && illegal_q[LAST];

`ifdef ALU_PIPE_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d, stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_ops_d    = stat_ops_q;
        stat_stalls_d = stat_stalls_q;
        if (fire && stat_ops_q != '1) stat_ops_d = stat_ops_q + 32'd1;
        if (in_valid && !in_ready && !flush && stat_stalls_q != '1)
            stat_stalls_d = stat_stalls_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q    <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_ops_q    <= stat_ops_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_ops    = stat_ops_q;
    assign stat_stalls = stat_stalls_q;
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!rst && accept && calc_illegal)
            $display("alu_pipe: unrecognised alu_ctl %0d, tag %0d", in_alu_ctl, in_tag);
    end
`endif

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the combinational execute-stage ALU. It accepts one reservation-station op per cycle: alu_ctl, two operands and a tag. It returns the result, tag and MTC0 pass/fail/done flags after a configurable number of register stages. Both sides use valid/ready backpressure, and a flush input kills all in-flight ops on branch mispredict.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a power of 2, at least 8
TAG_WIDTH, 6, reservation-station tag width
STAGES, 2, register stages from accept to output; legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  op offered
in_ready  out  1  unit can accept op this cycle
in_alu_ctl  in  alu_ctl_t  ALUCTL_* code from mips_core_pkg
in_op1  in  DATA_WIDTH  operand 1
in_op2  in  DATA_WIDTH  operand 2
in_tag  in  TAG_WIDTH  destination tag
flush  in  1  kill all in-flight ops
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_result  out  DATA_WIDTH  ALU result or branch outcome
out_tag  out  TAG_WIDTH  tag of result
out_pass  out  1  MTC0 pass
out_fail  out  1  MTC0 fail
out_done  out  1  MTC0 done
out_mtc0_op  out  DATA_WIDTH  op2 of the MTC0 op, 0 otherwise
out_illegal  out  1  alu_ctl was not a recognised code

Behaviour:
- Stage registers S[0..STAGES-1]. Each holds valid, result, tag, pass/fail/done, mtc0_op and illegal.
- The result is computed combinationally from the inputs and captured into S[0]. Later stages pass values through unchanged.
- Outputs come directly from S[STAGES-1] (registered).
- Accept: in_valid && in_ready at a rising edge.
- Latency: an op accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 when there is no stall. For STAGES=1, that is the cycle after acceptance.
- Output fire: out_valid && out_ready.
- Stage advance: S[k] loads S[k-1] when S[k] is empty or S[k] advances. The last stage advances on output fire.
- in_ready = !flush && (!S[0].valid || S[0] advances). This is combinational from out_ready through the stall chain.
- With out_ready low and all stages full: in_ready=0 and all registers hold.
- Throughput is 1 op/cycle when out_ready is held at 1.
- Flush: all valid bits clear at that edge, no op is accepted in that cycle, and out_valid=0 the next cycle.
  - If output fire and flush occur in the same cycle, the fired result counts as delivered.
  - Non-valid payload fields are don't-care.
- Reset: all valid bits are 0. out_valid, out_pass, out_fail, out_done, out_illegal, out_result, out_tag and out_mtc0_op all reset to 0, and in_ready=1 the cycle after reset.
  - Reset mid-operation discards all in-flight ops.
- Arithmetic, modulo 2^DATA_WIDTH, no overflow trap:
  - ADD, ADDU, SUB, SUBU.
  - AND, OR, XOR, NOR.
  - SLT is a signed compare; SLTU is unsigned. Both produce a zero-extended 0/1.
- Shifts use shamt = low log2(DATA_WIDTH) bits of the shift operand:
  - SLL, SRL and SRA shift op1 by op2.
  - SLLV, SRLV and SRAV shift op2 by op1.
  - SRA and SRAV are arithmetic.
- Branches produce result = TAKEN/NOT_TAKEN, zero-extended:
  - BA is always TAKEN.
  - BEQ and BNE compare op1 with op2.
  - BLEZ, BGTZ, BGEZ and BLTZ compare op1 signed against 0.
- NOP: result 0.
- MTC0_PASS, MTC0_FAIL and MTC0_DONE each set their one flag and mtc0_op = op2, with result 0. All flags are qualified by the stage valid bit.
- Any other code gives result 0 and illegal=1. Under SIMULATION it also prints a $display message once, on accept.

Optional Feature:
ALU_PIPE_STATS_EN
- Defined: adds output ports stat_ops[31:0] and stat_stalls[31:0], both reset to 0.
  - stat_ops increments on each output fire.
  - stat_stalls increments on each cycle with in_valid=1, in_ready=0 and flush=0.
  - Both saturate at 32'hFFFF_FFFF.
  - Flush and reset behave as above; flush does not clear the counters, only rst does.
- Undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- STAGES=2, out_ready=1. Issue ADD op1=32'h7FFF_FFFF op2=1 tag=5 -> out_valid one cycle after the accept edge, result=32'h8000_0000, tag=5. Back-to-back SLT op1=32'hFFFF_FFFF op2=0 -> result 1; SLTU with the same operands -> result 0 on the next cycle.
- SRA op1=32'h8000_0000 op2=32'h24 (shamt 4) -> 32'hF800_0000. SRLV op1=3 op2=32'hF0 -> 32'h1E.
- Backpressure: out_ready=0 while issuing 3 ops with STAGES=2 -> the first 2 are accepted, then in_ready=0 and the outputs hold. Raise out_ready -> results drain in order with no loss or duplication. With STATS, stat_stalls counts the stalled cycles.
- Flush: 2 ops in flight, pulse flush while in_valid=1 -> in_ready=0 that cycle, nothing emerges afterwards, and the next op issued appears with normal latency.
- MTC0_DONE op2=32'h1234 -> out_done=1 and out_mtc0_op=32'h1234 for exactly one output fire; pass and fail stay 0. BNE op1=op2=7 -> result NOT_TAKEN. Illegal code -> out_illegal=1 and result 0.
- Assert rst with the pipe full -> the next cycle has out_valid=0, in_ready=1 and all outputs 0. Repeat the directed tests with STAGES=1 and STAGES=4: latencies follow STAGES-1 and results are unchanged.
